// File: rtl/global_types.sv
// Shared constants and types for the SoC peripherals (UART register map, FSM states).
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package global_types;

  // Address decoder window: alu_out[11:8] == 4'hA selects the UART.
  localparam logic [3:0] UART_WINDOW = 4'hA;

  // UART register offsets, selected by alu_out[3:2].
  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_CTRL   = 2'd2;
  localparam logic [1:0] UART_DROP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/fifo_sync.sv
// Generic single-clock FIFO; head entry visible combinationally on rdata.
// Latency: a push is visible on rdata/empty the cycle after the write edge.
// Backpressure: push when full and pop when empty are ignored; caller watches full/empty.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the pre-pop count, so a push into a full FIFO is lost even with a pop.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; no reset needed since count guards every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU pushes bytes into a FIFO, FSM serialises them on tx.
// Latency: TXDATA write at edge N with FSM idle and enable set -> pop and tx falls at edge N+1.
// Backpressure: none on the bus; pushes into a full FIFO are dropped and counted in DROP.
module uart_tx_mmio
  import global_types::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx,
  output logic        busy
);

  localparam int           CW       = $clog2(CLKS_PER_BIT);
  localparam int           FCW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic           enable;
  logic [7:0]     drop_cnt;
  logic           push_req;
  logic           fifo_pop;
  logic [7:0]     fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_count;
  logic           unused_bits;

  uart_state_t    state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bit_idx, bit_n;
  logic [7:0]     shift, shift_n;
  logic           tx_n;
  logic           cnt_end;

  assign push_req    = we && (addr == UART_TXDATA);
  assign unused_bits = ^{wd[31:8], fifo_count};

  fifo_sync #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .wdata (wd[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // CTRL register: enable bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          enable <= 1'b0;
    else if (we && addr == UART_CTRL)   enable <= wd[0];
  end

  // DROP counter: saturating count of pushes lost to a full FIFO; any write clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                         drop_cnt <= '0;
    else if (we && addr == UART_DROP)                  drop_cnt <= '0;
    else if (push_req && fifo_full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

  // Combinational register read mux.
  always_comb begin
    rd = '0;
    case (addr)
      UART_STATUS: rd = {29'b0, fifo_full, fifo_empty, busy};
      UART_CTRL:   rd = {31'b0, enable};
      UART_DROP:   rd = {24'b0, drop_cnt};
      default:     rd = '0;
    endcase
  end

  assign cnt_end = (cnt == CNT_LAST);

  // Serial FSM next state; tx is derived from the next state so the line is registered.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    shift_n  = shift;
    fifo_pop = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_rdata;
          cnt_n    = '0;
          state_n  = START;
        end
      end
      START: begin
        if (cnt_end) begin
          cnt_n   = '0;
          bit_n   = 3'd0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt_end) begin
          cnt_n   = '0;
          shift_n = shift >> 1;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt_end) begin
          cnt_n = '0;
          // Chain straight into the next frame so there is no idle gap between frames.
          if (enable && !fifo_empty) begin
            fifo_pop = 1'b1;
            shift_n  = fifo_rdata;
            state_n  = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
      busy    <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        we    = 1'b0;
  logic [1:0]  addr  = 2'd0;
  logic [31:0] wd    = 32'd0;
  logic [31:0] rd;
  logic        tx;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .wd    (wd),
    .rd    (rd),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  // Register write captured at the next rising edge; returns 1ns after that edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clock);
    we = 1'b1; addr = a; wd = d;
    @(posedge clock);
    #1;
    we = 1'b0;
  endtask

  task automatic rdreg(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h2; exp_rd[2] = 32'h0; exp_rd[3] = 32'h0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      rdreg(2'(i), v);
      checks++;
      if (v !== exp_rd[i]) begin
        failures++;
        $display("FAIL reset_rd addr=%0d got=%h exp=%h", i, v, exp_rd[i]);
      end
    end
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_lines tx=%b busy=%b exp tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_single_frame;
    logic [31:0] v;
    logic [9:0]  frame;
    logic        e;
    frame = {1'b1, 8'hA5, 1'b0};
    wr(2'd2, 32'h1);
    wr(2'd0, 32'hA5);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL frame_busy_before got=%b exp=0", busy);
    end
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL frame_busy_rise got=%b exp=1", busy);
    end
    for (int k = 0; k < 10*CPB; k++) begin
      e = frame[k/CPB];
      checks++;
      if (tx !== e) begin
        failures++;
        $display("FAIL frame_tx cycle=%0d got=%b exp=%b", k, tx, e);
      end
      @(posedge clock); #1;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL frame_busy_end got=%b exp=0", busy);
    end
    rdreg(2'd1, v);
    checks++;
    if (v !== 32'h2) begin
      failures++;
      $display("FAIL frame_status_end got=%h exp=2", v);
    end
  endtask

  task automatic test_fifo_full;
    logic [31:0] v;
    logic [7:0]  bytes [4];
    logic [9:0]  frame;
    logic        e;
    int          bad_busy;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    wr(2'd2, 32'h0);
    wr(2'd0, 32'h11); wr(2'd0, 32'h22); wr(2'd0, 32'h33);
    wr(2'd0, 32'h44); wr(2'd0, 32'h55);
    rdreg(2'd1, v);
    checks++;
    if (v !== 32'h4) begin
      failures++;
      $display("FAIL full_status got=%h exp=4", v);
    end
    rdreg(2'd3, v);
    checks++;
    if (v !== 32'h1) begin
      failures++;
      $display("FAIL full_drop got=%h exp=1", v);
    end
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL full_idle_line tx=%b busy=%b exp tx=1 busy=0", tx, busy);
    end
    wr(2'd2, 32'h1);
    @(posedge clock); #1;
    bad_busy = 0;
    for (int k = 0; k < 4*10*CPB; k++) begin
      frame = {1'b1, bytes[k/(10*CPB)], 1'b0};
      e = frame[(k % (10*CPB)) / CPB];
      checks++;
      if (tx !== e) begin
        failures++;
        $display("FAIL b2b_tx cycle=%0d got=%b exp=%b", k, tx, e);
      end
      if (busy !== 1'b1) bad_busy++;
      @(posedge clock); #1;
    end
    checks++;
    if (bad_busy != 0) begin
      failures++;
      $display("FAIL b2b_busy_gap got=%0d idle cycles exp=0", bad_busy);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_busy_end got=%b exp=0", busy);
    end
  endtask

  task automatic test_drop;
    logic [31:0] v;
    int          n;
    wr(2'd2, 32'h0);
    for (int i = 1; i <= 5; i++) wr(2'd0, 32'(i));
    rdreg(2'd3, v);
    checks++;
    if (v !== 32'h2) begin
      failures++;
      $display("FAIL drop_two got=%h exp=2", v);
    end
    // Enable captured at edge M, push at M+1 coincides with the first pop.
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h66);
    rdreg(2'd1, v);
    checks++;
    if (v !== 32'h1) begin
      failures++;
      $display("FAIL drop_pushpop_status got=%h exp=1", v);
    end
    rdreg(2'd3, v);
    checks++;
    if (v !== 32'h3) begin
      failures++;
      $display("FAIL drop_pushpop_count got=%h exp=3", v);
    end
    wr(2'd3, 32'hFFFF_FFFF);
    rdreg(2'd3, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL drop_clear got=%h exp=0", v);
    end
    wr(2'd2, 32'h0);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(posedge clock); #1; n++;
    end
    rdreg(2'd1, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL drop_retained_status got=%h exp=0", v);
    end
    wr(2'd0, 32'h07);
    for (int i = 0; i < 300; i++) wr(2'd0, 32'hEE);
    rdreg(2'd3, v);
    checks++;
    if (v !== 32'hFF) begin
      failures++;
      $display("FAIL drop_saturate got=%h exp=ff", v);
    end
    rdreg(2'd1, v);
    checks++;
    if (v !== 32'h4) begin
      failures++;
      $display("FAIL drop_full_status got=%h exp=4", v);
    end
    wr(2'd2, 32'h1);
    n = 0;
    v = 32'h0;
    while (v !== 32'h2 && n < 400) begin
      @(posedge clock); #1; n++;
      rdreg(2'd1, v);
    end
    checks++;
    if (v !== 32'h2) begin
      failures++;
      $display("FAIL drop_drain got=%h exp=2", v);
    end
    wr(2'd2, 32'h0);
  endtask

  task automatic test_enable_clear;
    logic [31:0] v;
    int          e;
    int          bad;
    wr(2'd0, 32'h3C); wr(2'd0, 32'h00); wr(2'd0, 32'h00);
    wr(2'd2, 32'h1);
    repeat (10) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      failures++;
      $display("FAIL en_mid_data busy=%b tx=%b exp busy=1 tx=0", busy, tx);
    end
    wr(2'd2, 32'h0);
    e = 11;
    while (busy === 1'b1 && e < 200) begin
      @(posedge clock); #1; e++;
    end
    checks++;
    if (e != 41) begin
      failures++;
      $display("FAIL en_frame_end got=%0d edges exp=41", e);
    end
    rdreg(2'd1, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL en_status got=%h exp=0", v);
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL en_stays_idle got=%0d active cycles exp=0", bad);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    wr(2'd2, 32'h1);
    repeat (7) @(posedge clock);
    #1;
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre tx=%b busy=%b exp tx=0 busy=1", tx, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_async tx=%b busy=%b exp tx=1 busy=0", tx, busy);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    rdreg(2'd1, v);
    checks++;
    if (v !== 32'h2) begin
      failures++;
      $display("FAIL rst_status got=%h exp=2", v);
    end
    rdreg(2'd3, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL rst_drop got=%h exp=0", v);
    end
    rdreg(2'd2, v);
    checks++;
    if (v !== 32'h0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL rst_ctrl got=%h tx=%b exp ctrl=0 tx=1", v, tx);
    end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_fifo_full;
    test_drop;
    test_enable_clear;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
